// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer - microcode control unit for the 8-bit bus CPU.
//
// It holds the microstep counter. It decodes {opcode, step, flags} into the
// 16-bit control word that drives every bus driver and latch. It also owns
// instruction sequencing and the HLT latch.
//
// Ports:
//   clk        in   1       system clock, all state updates on posedge
//   clr        in   1       asynchronous active-high reset
//   instr      in   4       opcode (instruction register [7:4]), used live
//   ovf        in   1       carry/overflow flag, looked at in T2 only
//   zf         in   1       zero flag, looked at in T2 only
//   ctrl_word  out  16      control word: 15 HLT,14 MI,13 RI,12 RO,11 IO,10 II,
//                           9 AI,8 AO,7 EO,6 SU,5 BI,4 OI,3 CE,2 CO,1 J,0 FI
//   step       out  STEP_W  current microstep
//   fetch      out  1       high when step == 0
//   halted     out  1       latched halt status
//
// Optional build macro STEP_SKIP_EN:
//   When it is defined, a step >= 2 whose decoded word is zero returns straight
//   to fetch. When it is undefined, every instruction takes NSTEPS cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | sequencing microsteps
// HALT  | HLT executed; step frozen at 2, ctrl_word forced to 8000, exit only via clr

module ctrl_sequencer #(
    parameter int NSTEPS = 5,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [3:0]        instr,
    input  logic              ovf,
    input  logic              zf,
    output logic [15:0]       ctrl_word,
    output logic [STEP_W-1:0] step,
    output logic              fetch,
    output logic              halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t            state, state_nxt;
    logic [STEP_W-1:0] step_q, step_nxt;
    logic [15:0]       word;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= RUN;
            step_q <= '0;
        end else begin
            state  <= state_nxt;
            step_q <= step_nxt;
        end
    end

    // Microcode decode
    always_comb begin
        word = 16'h0000;
        case (step_q)
            STEP_W'(0): word = 16'h4004;
            STEP_W'(1): word = 16'h1408;
            STEP_W'(2): begin
                case (instr)
                    4'h1, 4'h2, 4'h3, 4'h4: word = 16'h4800;
                    4'h5:                   word = 16'h0A00;
                    4'h6:                   word = 16'h0802;
                    4'h7:                   word = ovf ? 16'h0802 : 16'h0000;
                    4'h8:                   word = zf  ? 16'h0802 : 16'h0000;
                    4'hE:                   word = 16'h0110;
                    4'hF:                   word = 16'h8000;
                    default:                word = 16'h0000;
                endcase
            end
            STEP_W'(3): begin
                case (instr)
                    4'h1:       word = 16'h1200;
                    4'h2, 4'h3: word = 16'h1020;
                    4'h4:       word = 16'h2100;
                    default:    word = 16'h0000;
                endcase
            end
            STEP_W'(4): begin
                case (instr)
                    4'h2:    word = 16'h0281;
                    4'h3:    word = 16'h02C1;
                    default: word = 16'h0000;
                endcase
            end
            default: word = 16'h0000;
        endcase
    end

    // Next state and step sequencing
    always_comb begin
        state_nxt = state;
        step_nxt  = step_q;
        if (state == HALT) begin
            step_nxt = step_q;
        end else if (word[15]) begin
            // HLT: the step freezes where it is (T2) from this edge on
            state_nxt = HALT;
            step_nxt  = step_q;
`ifdef STEP_SKIP_EN
        end else if (step_q >= STEP_W'(2) && word == 16'h0000) begin
            step_nxt = '0;
`endif
        end else if (step_q == STEP_W'(NSTEPS - 1)) begin
            step_nxt = '0;
        end else begin
            step_nxt = step_q + STEP_W'(1);
        end
    end

    assign halted    = (state == HALT);
    assign ctrl_word = halted ? 16'h8000 : word;
    assign step      = step_q;
    assign fetch     = (step_q == '0);

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  instr;
    logic        ovf;
    logic        zf;
    logic [15:0] ctrl_word;
    logic [2:0]  step;
    logic        fetch;
    logic        halted;

    int errors = 0;
    int checks = 0;

    ctrl_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .instr     (instr),
        .ovf       (ovf),
        .zf        (zf),
        .ctrl_word (ctrl_word),
        .step      (step),
        .fetch     (fetch),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // This pulses clr between clock edges. It is called at posedge+1.
    task automatic do_reset();
        clr = 1'b1;
        #1;
        clr = 1'b0;
        #1;
    endtask

    initial begin
        logic exp_fetch;
        int   ldi_len;

        clr = 1'b1; instr = 4'h0; ovf = 1'b0; zf = 1'b0;
        #2;
        check("rst_step",   16'(step), 16'h0000);
        check("rst_cw",     ctrl_word, 16'h4004);
        check("rst_fetch",  16'(fetch), 16'h0001);
        check("rst_halted", 16'(halted), 16'h0000);
        clr = 1'b0;

        // LDA, full five-step pass and wrap
        instr = 4'h1;
        check("lda_t0", ctrl_word, 16'h4004);
        tick(); check("lda_t1", ctrl_word, 16'h1408);
        tick(); check("lda_t2", ctrl_word, 16'h4800);
        tick(); check("lda_t3", ctrl_word, 16'h1200);
        tick(); check("lda_t4", ctrl_word, 16'h0000);
        check("lda_t4_step", 16'(step), 16'h0004);
        tick(); check("lda_wrap_step", 16'(step), 16'h0000);
        check("lda_wrap_cw", ctrl_word, 16'h4004);

        // SUB then ADD T4 words
        instr = 4'h3;
        tick(); tick(); tick();
        check("sub_t3", ctrl_word, 16'h1020);
        tick(); check("sub_t4", ctrl_word, 16'h02C1);
        tick(); instr = 4'h2;
        tick(); tick(); tick(); tick();
        check("add_t4", ctrl_word, 16'h0281);

        // Clear partway through T3 of ADD takes effect with no clock edge
        do_reset();
        instr = 4'h2;
        tick(); tick(); tick();
        check("add_t3", ctrl_word, 16'h1020);
        clr = 1'b1;
        #1;
        check("clr_async_step", 16'(step), 16'h0000);
        check("clr_async_cw", ctrl_word, 16'h4004);
        check("clr_async_halted", 16'(halted), 16'h0000);
        tick();
        check("clr_held_step", 16'(step), 16'h0000);
        clr = 1'b0;

        // Remaining T2/T3 words
        do_reset(); instr = 4'h4; tick(); tick();
        check("sta_t2", ctrl_word, 16'h4800);
        tick(); check("sta_t3", ctrl_word, 16'h2100);
        do_reset(); instr = 4'h5; tick(); tick();
        check("ldi_t2", ctrl_word, 16'h0A00);
        do_reset(); instr = 4'h6; tick(); tick();
        check("jmp_t2", ctrl_word, 16'h0802);
        do_reset(); instr = 4'hE; tick(); tick();
        check("out_t2", ctrl_word, 16'h0110);
        do_reset(); instr = 4'h9; tick(); tick();
        check("nop9_t2", ctrl_word, 16'h0000);

        // JC: the flag only matters in T2
        do_reset(); instr = 4'h7; ovf = 1'b1;
        tick(); tick();
        check("jc_taken", ctrl_word, 16'h0802);
        ovf = 1'b0; #1;
        check("jc_not_taken_live", ctrl_word, 16'h0000);
        ovf = 1'b1; #1;
        check("jc_retaken", ctrl_word, 16'h0802);
        tick();
        check("jc_t3", ctrl_word, 16'h0000);
        ovf = 1'b0; #1;
        check("jc_t3_ovf_toggle", ctrl_word, 16'h0000);
        tick();
`ifdef STEP_SKIP_EN
        check("jc_after_t3_step", 16'(step), 16'h0000);
`else
        check("jc_after_t3_step", 16'(step), 16'h0004);
`endif
        do_reset(); ovf = 1'b0; tick(); tick();
        check("jc_nt_t2", ctrl_word, 16'h0000);
        tick();
`ifdef STEP_SKIP_EN
        check("jc_nt_next_step", 16'(step), 16'h0000);
`else
        check("jc_nt_next_step", 16'(step), 16'h0003);
`endif

        // JZ is sensitive to zf only
        do_reset(); instr = 4'h8; zf = 1'b1; ovf = 1'b0;
        tick(); tick();
        check("jz_taken", ctrl_word, 16'h0802);
        zf = 1'b0; ovf = 1'b1; #1;
        check("jz_not_taken", ctrl_word, 16'h0000);
        zf = 1'b1; #1; tick();
        zf = 1'b0; #1;
        check("jz_t3_toggle", ctrl_word, 16'h0000);
        ovf = 1'b0;

        // HLT
        do_reset(); instr = 4'hF; tick(); tick();
        check("hlt_t2", ctrl_word, 16'h8000);
        check("hlt_t2_halted", 16'(halted), 16'h0000);
        tick();
        check("hlt_halted", 16'(halted), 16'h0001);
        check("hlt_step", 16'(step), 16'h0002);
        instr = 4'h0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hlt_hold_step", 16'(step), 16'h0002);
            check("hlt_hold_cw", ctrl_word, 16'h8000);
        end
        clr = 1'b1; #1;
        check("hlt_clr_step", 16'(step), 16'h0000);
        check("hlt_clr_cw", ctrl_word, 16'h4004);
        check("hlt_clr_halted", 16'(halted), 16'h0000);
        clr = 1'b0;

        // LDI then NOP: fetch cadence
        tick();
        do_reset();
`ifdef STEP_SKIP_EN
        ldi_len = 4;
`else
        ldi_len = 5;
`endif
        for (int c = 0; c < 10; c++) begin
            instr = (c < ldi_len) ? 4'h5 : 4'h0;
`ifdef STEP_SKIP_EN
            exp_fetch = (c == 0 || c == 4 || c == 7);
`else
            exp_fetch = (c == 0 || c == 5);
`endif
            #1;
            check($sformatf("fetch_cyc%0d", c), 16'(fetch), 16'(exp_fetch));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
